// File: rtl/xunitm_pkg.sv
// SHA-256 message-schedule helpers shared with the compression unit:
// word counts, state encoding and the small-sigma functions.
package xunitm_pkg;

    localparam int MSG_WORDS   = 16;
    localparam int SCHED_WORDS = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ACTIVE,
        S_FINISH
    } state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

endpackage

// File: rtl/xunitm.sv
// SHA-256 message-schedule producer: takes W0..W15 from in0 after a programmable
// start delay, then expands W16..W63 from a 16-word shift window, one word per cycle.
module xunitm
    import xunitm_pkg::*;
#(
    parameter int DELAY_W = 32,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    input  logic [DELAY_W-1:0] delay0
);

    state_e                              state_q, state_d;
    logic [DELAY_W-1:0]                  delay_q, delay_d;
    logic [6:0]                          cnt_q, cnt_d;
    logic [MSG_WORDS-1:0][DATA_W-1:0]    win_q, win_d;
    logic [DATA_W-1:0]                   out_q, out_d;
    logic [DATA_W-1:0]                   w_exp, w_new;

    // win_q[0] holds W[cnt-1], so W[cnt-k] sits at index k-1.
    assign w_exp = DATA_W'(sig1(32'(win_q[1])) + 32'(win_q[6])
                         + sig0(32'(win_q[14])) + 32'(win_q[15]));
    assign w_new = (cnt_q < 7'(MSG_WORDS)) ? in0 : w_exp;

    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        out_d   = out_q;
        if (run) begin
            state_d = S_DELAY;
            delay_d = delay0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (delay_q != '0) begin
                        delay_d = delay_q - DELAY_W'(1);
                    end else begin
                        win_d   = {win_q[MSG_WORDS-2:0], in0};
                        out_d   = in0;
                        cnt_d   = 7'd1;
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    win_d = {win_q[MSG_WORDS-2:0], w_new};
                    out_d = w_new;
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == 7'(SCHED_WORDS - 1)) state_d = S_FINISH;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            delay_q <= '0;
            cnt_q   <= '0;
            win_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            out_q   <= out_d;
        end
    end

    assign out0 = out_q;
    assign done = (state_q == S_IDLE) || (state_q == S_FINISH);

endmodule

// File: tb/tb_xunitm.sv
// Directed bench for xunitm: expected schedule words come from an array-based
// SHA-256 reference and flow through a scoreboard queue.
module tb_xunitm;

    typedef logic [31:0] msg_t   [16];
    typedef logic [31:0] sched_t [64];

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        done;
    logic [31:0] in0;
    logic [31:0] out0;
    logic [31:0] delay0;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] sb_q [$];
    logic [31:0] last_exp;
    sched_t      got;

    xunitm #(.DELAY_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .done  (done),
        .in0   (in0),
        .out0  (out0),
        .delay0(delay0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic sched_t ref_sched(input msg_t m);
        sched_t w;
        logic [31:0] a, b;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else begin
                a = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                b = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = b + w[t-7] + a + w[t-16];
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues run, walks the delay, then drives/checks n_out schedule words.
    task automatic run_block(input msg_t m, input int d, input int n_out);
        sched_t e;
        logic [31:0] x;
        e = ref_sched(m);
        run = 1'b1; delay0 = d; in0 = $urandom;
        tick();
        run = 1'b0;
        chk("hold_at_run", out0, last_exp);
        chk("done_at_run", {31'd0, done}, 32'd0);
        for (int i = 0; i < d; i++) begin
            in0 = $urandom;
            tick();
            chk("hold_in_delay", out0, last_exp);
            chk("done_in_delay", {31'd0, done}, 32'd0);
        end
        for (int t = 0; t < n_out; t++) begin
            in0 = (t < 16) ? m[t] : $urandom;
            sb_q.push_back(e[t]);
            tick();
            x = sb_q.pop_front();
            chk($sformatf("w%0d", t), out0, x);
            chk($sformatf("done_w%0d", t), {31'd0, done}, (t == 63) ? 32'd1 : 32'd0);
            got[t] = out0;
            last_exp = x;
        end
    endtask

    task automatic rand_msg(output msg_t m);
        for (int i = 0; i < 16; i++) m[i] = $urandom;
    endtask

    initial begin
        msg_t abc, ma, mb, mc;
        rst = 1'b1; run = 1'b0; in0 = '0; delay0 = '0;
        last_exp = '0;
        #3;
        chk("reset_out0", out0, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_done", {31'd0, done}, 32'd1);

        for (int i = 0; i < 16; i++) abc[i] = '0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        run_block(abc, 0, 64);
        chk("abc_w0",  got[0],  32'h61626380);
        chk("abc_w15", got[15], 32'h00000018);
        chk("abc_w16", got[16], 32'h61626380);
        chk("abc_w17", got[17], 32'h000F0000);
        chk("abc_w18", got[18], 32'h7DA86405);
        chk("abc_w63", got[63], 32'h12B1EDEB);

        for (int i = 0; i < 4; i++) begin
            in0 = $urandom;
            tick();
            chk("finish_hold", out0, 32'h12B1EDEB);
            chk("finish_done", {31'd0, done}, 32'd1);
        end

        rand_msg(mc);
        run_block(mc, 0, 64);

        rand_msg(ma);
        run_block(ma, 5, 64);

        rand_msg(ma);
        rand_msg(mb);
        run_block(ma, 3, 30);
        run_block(mb, 2, 64);

        rand_msg(ma);
        run_block(ma, 1, 11);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out0", out0, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd1);
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in0 = $urandom;
            tick();
            chk("post_rst_out0", out0, 32'd0);
            chk("post_rst_done", {31'd0, done}, 32'd1);
        end

        rand_msg(mb);
        run_block(mb, 1, 64);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xunitm.md
XUNITM -- requirements
Module: xunitM

Interface
REQ-001 Parameter DELAY_W, 32, width of the start-delay configuration.
REQ-002 Parameter DATA_W, 32, data width; the SHA-256 function SHALL be exact only at 32.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  start/restart pulse, sampled on the clock edge.
REQ-006 done  output  1  high when idle or finished, low while the delay or schedule is in progress.
REQ-007 in0  input  DATA_W  message word stream, words W0..W15 in order.
REQ-008 out0  output  DATA_W  registered schedule word W[t], tagged versat_latency = 1.
REQ-009 delay0  input  DELAY_W  configuration, the number of idle edges between run and sampling W0.

Function
REQ-010 The block SHALL be the SHA-256 message-schedule producer, emitting W0..W63 one per cycle, so that the out0 stream feeds the compression unit's w input.
REQ-011 The state machine SHALL have the states IDLE, DELAY, ACTIVE and FINISH.
REQ-012 run=1 at an edge (any state) SHALL load delay <= delay0 and cnt <= 0, and SHALL enter DELAY; run has priority over all other transitions.
REQ-013 In DELAY, an edge with delay != 0 SHALL decrement delay.
REQ-014 In DELAY, an edge with delay == 0 SHALL:
- sample in0 as W0;
- shift it into the 16-word window;
- drive out0 <= W0;
- set cnt <= 1 and enter ACTIVE.
REQ-015 In ACTIVE, each edge SHALL produce W[cnt], shift it into the window and drive it on out0, then increment cnt.
- cnt < 16: W[cnt] = in0.
- cnt >= 16: W[cnt] = s1(W[cnt-2]) + W[cnt-7] + s0(W[cnt-15]) + W[cnt-16], mod 2^32.
REQ-016 s0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-017 The edge that produces W63 SHALL enter FINISH; FINISH SHALL hold out0 = W63 and the window unchanged until the next run.
REQ-018 Timing: with run sampled at edge E0, W[t] SHALL be sampled and appear on out0 after edge E(1+delay0+t).
REQ-019 done SHALL be combinational from state: 1 in IDLE and FINISH, 0 in DELAY and ACTIVE.
REQ-020 delay0 = 0 SHALL sample W0 at the first edge after run.
REQ-021 in0 SHALL be ignored at all times except during the 16 sampling edges.
REQ-022 Windowing SHALL use a 16-entry shift register; there SHALL be no RAM and no wrap-around indexing.
REQ-023 cnt SHALL be 7 bits wide and SHALL never exceed 64.

Reset
REQ-024 rst=1 SHALL asynchronously force:
- state = IDLE;
- delay = 0, cnt = 0;
- all 16 window words = 0;
- out0 = 0, so done = 1.
REQ-025 rst asserted mid-DELAY or mid-ACTIVE SHALL abort the schedule with no partial output retained; rst has priority over run.

Structure
REQ-026 The functions ROTR, SHR, s0 and s1 and the constants MSG_WORDS = 16 and SCHED_WORDS = 64 SHALL live in the shared SHA-256 include used by the compression unit.
REQ-027 No sub-module SHALL be instantiated; the window and the expander SHALL be local to xunitM.

Verification
REQ-028 Reset: assert rst mid-ACTIVE -> out0 = 0, done = 1 immediately; no further output until run.
REQ-029 Padded "abc" block with delay0 = 0 -> the bench SHALL check every word against a reference model, and these anchors:
- W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018;
- W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405;
- W63 = 0x12B1EDEB.
REQ-030 Delay: run with delay0 = 5 -> W0 sampled at E6 and W63 at E69; done is 0 through E68 and 1 after E69.
REQ-031 Restart: run re-asserted at cnt = 30 -> the schedule restarts from DELAY and the new block's W values are correct with no stale-window contamination.
REQ-032 Input isolation: in0 toggled randomly outside the 16 sampling edges -> W16..W63 unaffected.
REQ-033 Back-to-back blocks: a run issued in FINISH -> out0 holds W63 until the new W0 edge, and the second block's schedule is correct.
